// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan chain controller and its flop chain.
package scan_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int unsigned MIN_WIDTH = 2;

endpackage

// File: rtl/dff_chain.sv
// WIDTH-long D flip-flop chain; flop[i] takes flop[i+1] while scan_en is high,
// flop[WIDTH-1] takes scan_in, flop[0] drives scan_out.
module dff_chain
   import scan_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             scan_en,
   input  logic             scan_in,
   output logic             scan_out,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   if (WIDTH < MIN_WIDTH) begin : g_bad_width
      $error("dff_chain: WIDTH must be at least 2");
   end

   // Each bit's d input is its upstream neighbour; the mux holds when scan_en is low.
   always_comb begin
      q_d = q_q;
      if (scan_en) begin
         q_d = {scan_in, q_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q        = q_q;
   assign scan_out = q_q[0];

endmodule

// File: rtl/scan_chain_ctrl.sv
// Loads a parallel word into a serial flop chain LSB-first while capturing the
// chain's previous contents, then returns that old word on a result handshake.
//
// state | meaning
// IDLE  | ready for a new word, chain idle
// SHIFT | WIDTH cycles of scan_en, one bit out and one bit captured per cycle
// DONE  | captured old word presented until result_ready
module scan_chain_ctrl
   import scan_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   output logic             scan_en,
   output logic             scan_in,
   input  logic             scan_out,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] result_data,
   output logic             busy
);

   localparam int unsigned   CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   if (WIDTH < MIN_WIDTH) begin : g_bad_width
      $error("scan_chain_ctrl: WIDTH must be at least 2");
   end

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-2:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic             scan_en_q, scan_en_d;
   logic             scan_in_q, scan_in_d;
   logic             rvalid_q, rvalid_d;

   // shreg holds only the bits still to be sent; the current bit already sits in scan_in_q.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shreg_d   = shreg_q;
      cap_d     = cap_q;
      scan_en_d = scan_en_q;
      scan_in_d = scan_in_q;
      rvalid_d  = rvalid_q;
      case (state_q)
         IDLE: begin
            if (load_valid) begin
               state_d   = SHIFT;
               cnt_d     = '0;
               shreg_d   = load_data[WIDTH-1:1];
               scan_en_d = 1'b1;
               scan_in_d = load_data[0];
            end
         end
         SHIFT: begin
            shreg_d   = shreg_q >> 1;
            cap_d     = {scan_out, cap_q[WIDTH-1:1]};
            scan_in_d = shreg_q[0];
            if (cnt_q == CNT_LAST) begin
               state_d   = DONE;
               scan_en_d = 1'b0;
               scan_in_d = 1'b0;
               rvalid_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (result_ready) begin
               state_d  = IDLE;
               rvalid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         shreg_q   <= '0;
         cap_q     <= '0;
         scan_en_q <= 1'b0;
         scan_in_q <= 1'b0;
         rvalid_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shreg_q   <= shreg_d;
         cap_q     <= cap_d;
         scan_en_q <= scan_en_d;
         scan_in_q <= scan_in_d;
         rvalid_q  <= rvalid_d;
      end
   end

   assign load_ready   = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign scan_en      = scan_en_q;
   assign scan_in      = scan_in_q;
   assign result_valid = rvalid_q;
   assign result_data  = cap_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Scoreboard bench for scan_chain_ctrl driving a real dff_chain; the reference
// model tracks chain contents as whole words.
module tb_scan_chain_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n, chain_rst_n;
   logic         load_valid, load_ready;
   logic [W-1:0] load_data;
   logic         scan_en, scan_in, scan_out;
   logic         result_valid, result_ready;
   logic [W-1:0] result_data;
   logic         busy;
   logic [W-1:0] chain_q;

   always #5 clk = ~clk;

   scan_chain_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
      .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out),
      .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
      .busy(busy)
   );

   dff_chain #(.WIDTH(W)) chain (
      .clk(clk), .rst_n(chain_rst_n), .scan_en(scan_en), .scan_in(scan_in),
      .scan_out(scan_out), .q(chain_q)
   );

   typedef struct {
      logic [W-1:0] exp;
      logic [W-1:0] chain;
      int           acc;
   } exp_t;

   exp_t         sbq[$];
   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   logic [W-1:0] model_chain = '0;
   bit           shift_active = 0;
   int           shift_start = 0;
   logic [W-1:0] shift_data = '0;
   bit           prev_valid = 0;
   bit           rand_ready = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Chain after k shift edges: the new word streams in from the top, old word falls off the bottom.
   function automatic logic [W-1:0] partial(logic [W-1:0] old, logic [W-1:0] d, int k);
      logic [2*W-1:0] stream;
      stream = {d, old};
      stream = stream >> k;
      return stream[W-1:0];
   endfunction

   // Called at the negedge before the accepting edge.
   function automatic void accept_push(logic [W-1:0] d);
      exp_t e;
      e.exp   = model_chain;
      e.chain = d;
      e.acc   = cyc + 1;
      sbq.push_back(e);
      model_chain  = d;
      shift_active = 1;
      shift_start  = cyc + 1;
      shift_data   = d;
   endfunction

   always @(negedge clk) begin
      bit exp_en;
      if (rst_n) begin
         exp_en = shift_active && (cyc >= shift_start) && (cyc < shift_start + W);
         check("scan_en", 32'(scan_en), 32'(exp_en));
         if (exp_en) check("scan_in", 32'(scan_in), 32'(shift_data[cyc - shift_start]));
         if (result_valid) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL result_unexpected: got result_valid=1 with data %0h, required no result", result_data);
            end else begin
               if (!prev_valid) check("latency", 32'(cyc - sbq[0].acc), 32'(W));
               check("result_data", 32'(result_data), 32'(sbq[0].exp));
               if (result_ready) begin
                  check("chain_q", 32'(chain_q), 32'(sbq[0].chain));
                  void'(sbq.pop_front());
               end
            end
         end
         prev_valid = result_valid;
      end else begin
         prev_valid = 0;
      end
   end

   always begin
      @(posedge clk);
      #1;
      if (rand_ready) result_ready = 1'($urandom_range(0, 1));
   end

   task automatic check_reset_vals(string tag);
      check({tag, "_load_ready"}, 32'(load_ready), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_scan_en"}, 32'(scan_en), 32'd0);
      check({tag, "_scan_in"}, 32'(scan_in), 32'd0);
      check({tag, "_result_valid"}, 32'(result_valid), 32'd0);
      check({tag, "_result_data"}, 32'(result_data), 32'd0);
   endtask

   task automatic do_load(input logic [W-1:0] d);
      int n = 0;
      @(posedge clk);
      #1;
      load_valid = 1'b1;
      load_data  = d;
      @(negedge clk);
      while (!load_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("load_accept_timeout", 32'(load_ready), 32'd1);
      if (load_ready) accept_push(d);
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      load_data  = W'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while ((sbq.size() != 0 || !load_ready) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", 32'(sbq.size()), 32'd0);
   endtask

   // Reset sampled at the k-th shift edge, so the chain has shifted k times.
   task automatic reset_mid(input logic [W-1:0] d, input int k);
      logic [W-1:0] old;
      old = model_chain;
      do_load(d);
      repeat (k - 1) @(posedge clk);
      #1;
      rst_n = 1'b0;
      sbq.delete();
      shift_active = 0;
      model_chain  = partial(old, d, k);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_vals("rst_mid");
   endtask

   initial begin
      int n;
      int count;
      int last_acc;
      rst_n        = 1'b0;
      chain_rst_n  = 1'b0;
      load_valid   = 1'b1;
      load_data    = 8'h5A;
      result_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_reset_vals("reset");
      end
      @(posedge clk);
      #1;
      load_valid  = 1'b0;
      rst_n       = 1'b1;
      chain_rst_n = 1'b1;
      @(negedge clk);
      check_reset_vals("post_reset");

      result_ready = 1'b1;
      do_load(8'hA5);
      drain();
      do_load(8'h3C);
      drain();

      // back-pressure with a competing load offered
      result_ready = 1'b0;
      do_load(W'($urandom));
      n = 0;
      while (!result_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("bp_valid_seen", 32'(result_valid), 32'd1);
      @(posedge clk);
      #1;
      load_valid = 1'b1;
      load_data  = ~model_chain;
      repeat (5) begin
         @(negedge clk);
         check("bp_load_ready", 32'(load_ready), 32'd0);
         check("bp_result_valid", 32'(result_valid), 32'd1);
      end
      @(posedge clk);
      #1;
      load_valid   = 1'b0;
      result_ready = 1'b1;
      drain();

      reset_mid(8'hFF, 4);
      do_load(8'h00);
      drain();

      // throughput with both handshakes tied high
      result_ready = 1'b1;
      @(posedge clk);
      #1;
      load_valid = 1'b1;
      load_data  = W'($urandom);
      count      = 0;
      last_acc   = 0;
      n          = 0;
      while (count < 8 && n < 200) begin
         @(negedge clk);
         n++;
         if (load_ready) begin
            if (count > 0) check("interval", 32'(cyc + 1 - last_acc), 32'(W + 2));
            last_acc = cyc + 1;
            accept_push(load_data);
            count++;
            @(posedge clk);
            #1;
            load_data = W'($urandom);
         end
      end
      load_valid = 1'b0;
      check("tp_count", 32'(count), 32'd8);
      drain();

      rand_ready = 1;
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         if (i == 10) reset_mid(W'($urandom), $urandom_range(1, W - 1));
         else do_load(W'($urandom));
      end
      rand_ready = 0;
      @(posedge clk);
      #1;
      result_ready = 1'b1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Sequencing controller for a serial chain of WIDTH D flip-flops (shared clock, per-flop d/q). It accepts a parallel word over a valid/ready handshake and shifts it into the chain LSB-first. During the same shift it captures the chain's previous contents from the chain output, then presents that old word on a result handshake. It sits between a register-programming master and any flop chain built from the team's D flip-flop cell.

## Interface
- WIDTH, 8: chain length and word width in bits; legal range is WIDTH >= 2.
- clk  input  1  rising-edge clock, shared with the chain flops.
- rst_n  input  1  reset; synchronous, active-low.
- load_valid  input  1  master offers load_data.
- load_ready  output  1  controller can accept a word.
- load_data  input  WIDTH  word to shift into the chain.
- scan_en  output  1  high during shift cycles; gates the chain clock-enable/mux.
- scan_in  output  1  serial data driven to the chain input flop (flop[WIDTH-1]).
- scan_out  input  1  q of the chain's last flop (flop[0]).
- result_valid  output  1  captured old chain word available.
- result_ready  input  1  consumer takes result_data.
- result_data  output  WIDTH  chain contents before the most recent load.
- busy  output  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: load_ready=1. On load_valid&&load_ready, latch load_data into a shift register, clear the bit counter and go to SHIFT.
  - SHIFT: scan_en=1 and scan_in=shreg[0]. Each cycle:
    - shreg shifts right.
    - capture register shifts right with scan_out entering at bit WIDTH-1.
    - counter increments.
    - When counter==WIDTH-1, go to DONE.
  - DONE: result_valid=1 and result_data=capture register. On result_ready go to IDLE.
- Chain convention: flop[i] feeds flop[i-1] when scan_en is high. After WIDTH shift cycles flop[i]=load_data[i]. The chain holds its value when scan_en is low.
- Captured word: result_data[k] is the old flop[k], sampled at the edge that ends shift cycle k.
- load_data is ignored outside the accept cycle. load_ready is low in SHIFT and DONE.
- Counter width is $clog2(WIDTH). The counter never wraps inside SHIFT and is cleared on entry to SHIFT.
- result_data is held stable while result_valid is high and result_ready is low.
- Accepting a new load requires the DONE->IDLE transition first; there is no DONE->SHIFT bypass.

## Timing
- Reset: any cycle with rst_n=0 forces state IDLE and sets every output to its reset value, taking effect at the next edge:
  - load_ready=1
  - scan_en=0, scan_in=0
  - result_valid=0, result_data=0
  - busy=0
- Accept edge E0; SHIFT occupies cycles E0+1..E0+WIDTH. result_valid rises in cycle E0+WIDTH+1.
- Load-to-result latency is WIDTH+1 cycles. Minimum load-to-load interval is WIDTH+2 cycles, reached when result_ready is tied high.
- scan_en and scan_in are registered outputs (no combinational path from inputs). load_ready is a decode of the state register.
- Reset mid-SHIFT: the controller aborts and the captured word is discarded. Chain contents are partially shifted and undefined to the master; the next load fully overwrites the chain, but the result it returns reflects the partial chain contents.
- Reset in DONE: the pending result is dropped and result_valid is low in the following cycle.
- load_valid held high during SHIFT/DONE is not accepted and must not disturb the shift.

## Structure
- Shared package scan_ctrl_pkg holds:
  - the state enum (IDLE, SHIFT, DONE, 2-bit encoding);
  - the WIDTH lower-bound check constant.
- One sub-module is natural: dff_chain, the WIDTH-long chain of D flip-flop instances with a scan_en mux. The controller does not instantiate it; the bench and top level do.
- Controller RTL: state register, counter, load shift register, capture shift register, output registers.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with load_valid=1 -> load_ready=1, busy=0, scan_en=0, result_valid=0, result_data=0; nothing is accepted.
- First load: chain cleared, load 8'hA5 -> scan_en high for exactly 8 cycles with scan_in sequence 1,0,1,0,0,1,0,1. result_valid arrives at the 9th cycle after accept with result_data=8'h00, and the chain holds 8'hA5.
- Second load: load 8'h3C -> result_data=8'hA5 and the chain holds 8'h3C.
- Back-pressure: keep result_ready=0 for 5 cycles in DONE -> result_valid and result_data stay stable, load_ready stays 0, and a concurrent load_valid is ignored.
- Reset mid-shift: pulse rst_n=0 at shift cycle 3 of a load of 8'hFF -> all outputs are at reset values after the next edge. A following load of 8'h00 completes normally with a latency of 9.
- Throughput: result_ready tied 1 and load_valid tied 1 -> accepts are exactly 10 cycles apart for WIDTH=8, and every result equals the previous load's data.
